regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Arbitrates the register file's single write port between two writeback sources.
//  - Fast source: ALU, single-cycle results.
//  - Slow source: load / multi-cycle unit. Its results are buffered in a DEPTH-entry FIFO.
//  Keeps a pending-write scoreboard for slow-path destinations and raises a read-hazard stall.
//  Sits between the execute/memory stages and the register file write port.
// PARAMETERS
//  XLEN          32  data width
//  DEPTH         4   slow-path FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  3   consecutive fast grants tolerated while the FIFO head waits
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-low reset
//  alu_wb_valid  in   1       fast write request
//  alu_wb_ready  out  1       fast request accepted this cycle
//  alu_wb_rd     in   5       fast destination register
//  alu_wb_data   in   XLEN    fast write data
//  mem_wb_valid  in   1       slow write request (enqueue)
//  mem_wb_ready  out  1       FIFO can accept
//  mem_wb_rd     in   5       slow destination register
//  mem_wb_data   in   XLEN    slow write data
//  pend_set_valid in  1       slow op issued; mark pend_set_rd pending
//  pend_set_rd   in   5       destination of the issued slow op
//  rs1_addr      in   5       read address 1 to check
//  rs2_addr      in   5       read address 2 to check
//  hazard_stall  out  1       rs1 or rs2 has a pending slow write
//  rf_we         out  1       register file write enable (registered)
//  rf_rd         out  5       register file write address (registered)
//  rf_wdata      out  XLEN    register file write data (registered)
//  fifo_count    out  clog2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  - Reset (rst==0 at a posedge): FIFO emptied and in-flight entries discarded; fifo_count=0,
//    starve_cnt=0, all pending bits=0, rf_we=0, rf_rd=0, rf_wdata=0. Mid-operation reset drops all traffic.
//  - Enqueue on mem_wb_valid && mem_wb_ready.
//    - mem_wb_ready = (fifo_count != DEPTH), based on current state only.
//    - At full, no enqueue occurs even if a pop happens in the same cycle.
//  - alu_wb_ready = !(fifo_count!=0 && starve_cnt>=STARVE_LIMIT); depends on state only, never on valid.
//  - Grant, evaluated each cycle:
//    - Slow wins if the FIFO is non-empty and (!alu_wb_valid or starve_cnt>=STARVE_LIMIT). The head is popped.
//    - Otherwise fast wins if alu_wb_valid.
//    - Otherwise no grant.
//  - starve_cnt:
//    - cleared when slow is granted or the FIFO is empty;
//    - incremented (saturating at STARVE_LIMIT) when fast is granted while the FIFO is non-empty.
//  - Write port, 1-cycle latency: on the edge after a grant, rf_rd/rf_wdata <= winner's rd/data and
//    rf_we <= (rd!=0).
//    - With no grant, rf_we<=0 and rf_rd/rf_wdata hold their values.
//    - rd==0 requests are consumed (ready/pop as normal) but never assert rf_we.
//  - Scoreboard: 32 pending bits; x0 is never pending.
//    - Set: pend_set_valid && pend_set_rd!=0 sets pending[pend_set_rd].
//    - Clear: pending[rf_rd] is cleared at the edge ending a cycle in which rf_we=1 and that write came
//      from the slow path (a registered src flag). The register file captures the data on that same edge.
//    - Set and clear of the same register in the same cycle: set wins.
//    - Fast-path writes never touch pending bits.
//  - hazard_stall = pending[rs1_addr] | pending[rs2_addr], combinational; address 0 always returns 0.
//  - FIFO pointers wrap modulo DEPTH. fifo_count = enq - deq each cycle, allowing simultaneous enq+deq
//    when not full.
// TESTING
//  1. Fill FIFO with 2 entries and set pending[9], then hold rst=0 for 2 cycles
//     -> fifo_count=0, rf_we=0, hazard_stall=0 (rs1=9), mem_wb_ready=1.
//  2. alu_wb_valid, rd=5, data=0xDEADBEEF, FIFO empty
//     -> alu_wb_ready=1; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
//  3. FIFO holds {rd=7, 0x11}; alu_wb_valid held high with rd=3
//     -> fast granted 3 cycles, then alu_wb_ready=0 and slow popped;
//     -> rf_rd=7, rf_wdata=0x11 one cycle later; fifo_count=0, starve_cnt=0.
//  4. alu_wb_valid held high (STARVE_LIMIT=3); mem_wb_valid asserted with 6 distinct entries
//     -> 4 enqueued, mem_wb_ready drops to 0 at fifo_count=4, 5th held;
//     -> after the slow pop in cycle 4, ready=1 and the 5th enqueues; slow writes retire in FIFO order.
//  5. pend_set rd=9; rs1_addr=9
//     -> hazard_stall=1 until the cycle rf_we=1 with rf_rd=9 (slow), still 1 that cycle, 0 the next.
//     -> Also: pend_set and clear of rd=9 in the same cycle -> remains pending.
//  6. Slow write rd=0, data=0xFFFF
//     -> popped, fifo_count decrements, rf_we stays 0; a fast write to rd=0 likewise never asserts rf_we.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: ALU (fast) vs load/multi-cycle (slow, FIFO-buffered) writebacks.
// Latency: one cycle from grant to rf_we/rf_rd/rf_wdata; hazard_stall is combinational.
// Backpressure: mem_wb_ready drops only when the FIFO is full; alu_wb_ready drops while a starved FIFO head is forced out.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   alu_wb_valid/ready/rd/data        fast writeback request
//   mem_wb_valid/ready/rd/data        slow writeback enqueue into the FIFO
//   pend_set_valid/rd                 mark a slow destination pending at issue
//   rs1_addr, rs2_addr, hazard_stall  read-hazard check against pending slow writes
//   rf_we, rf_rd, rf_wdata            registered register file write port
//   fifo_count                        slow FIFO occupancy
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wb_valid,
    output logic                       alu_wb_ready,
    input  logic [4:0]                 alu_wb_rd,
    input  logic [XLEN-1:0]            alu_wb_data,
    input  logic                       mem_wb_valid,
    output logic                       mem_wb_ready,
    input  logic [4:0]                 mem_wb_rd,
    input  logic [XLEN-1:0]            mem_wb_data,
    input  logic                       pend_set_valid,
    input  logic [4:0]                 pend_set_rd,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       hazard_stall,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]      fifo_rd  [DEPTH];
    logic [XLEN-1:0] fifo_dat [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     pending;
    logic [31:0]     pending_nxt;
    logic            rf_src_slow;

    logic fifo_nonempty;
    logic starved;
    logic enq;
    logic slow_grant;
    logic fast_grant;

    assign fifo_nonempty = (fifo_count != '0);
    assign starved       = (starve_cnt >= STARVE_MAX);
    assign mem_wb_ready  = (fifo_count != FULL_CNT);
    assign alu_wb_ready  = !(fifo_nonempty && starved);
    assign enq           = mem_wb_valid && mem_wb_ready;

    // Slow head goes when the ALU is idle or has been favoured too long.
    assign slow_grant = fifo_nonempty && (!alu_wb_valid || starved);
    assign fast_grant = alu_wb_valid && !slow_grant;

    // FIFO storage needs no reset: occupancy and pointers decide validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]  <= mem_wb_rd;
            fifo_dat[wr_ptr] <= mem_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (enq)        wr_ptr <= wr_ptr + 1'b1;
            if (slow_grant) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(enq) - CW'(slow_grant);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (slow_grant || !fifo_nonempty) begin
            starve_cnt <= '0;
        end else if (fast_grant && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we       <= 1'b0;
            rf_rd       <= '0;
            rf_wdata    <= '0;
            rf_src_slow <= 1'b0;
        end else if (slow_grant) begin
            rf_we       <= (fifo_rd[rd_ptr] != 5'd0);
            rf_rd       <= fifo_rd[rd_ptr];
            rf_wdata    <= fifo_dat[rd_ptr];
            rf_src_slow <= 1'b1;
        end else if (fast_grant) begin
            rf_we       <= (alu_wb_rd != 5'd0);
            rf_rd       <= alu_wb_rd;
            rf_wdata    <= alu_wb_data;
            rf_src_slow <= 1'b0;
        end else begin
            rf_we       <= 1'b0;
            rf_src_slow <= 1'b0;
        end
    end

    // Clear retires the slow write being presented now; a new issue to the
    // same register in the same cycle must survive, so set is applied last.
    always_comb begin
        pending_nxt = pending;
        if (rf_we && rf_src_slow) begin
            pending_nxt[rf_rd] = 1'b0;
        end
        if (pend_set_valid && (pend_set_rd != 5'd0)) begin
            pending_nxt[pend_set_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // pending[0] is held at zero, so x0 never stalls.
    assign hazard_stall = pending[rs1_addr] | pending[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic        alu_wb_ready;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mem_wb_valid;
    logic        mem_wb_ready;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        pend_set_valid;
    logic [4:0]  pend_set_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_ready   (alu_wb_ready),
        .alu_wb_rd      (alu_wb_rd),
        .alu_wb_data    (alu_wb_data),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_ready   (mem_wb_ready),
        .mem_wb_rd      (mem_wb_rd),
        .mem_wb_data    (mem_wb_data),
        .pend_set_valid (pend_set_valid),
        .pend_set_rd    (pend_set_rd),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .hazard_stall   (hazard_stall),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wdata       (rf_wdata),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  q_rd  [$];
        logic [31:0] q_dat [$];
        logic        exp_rdy [6];
        int idx;
        int cyc;

        rst = 1'b0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        mem_wb_valid = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
        pend_set_valid = 1'b0; pend_set_rd = '0;
        rs1_addr = '0; rs2_addr = '0;
        step(); step();
        rst = 1'b1;
        chk("init_count", 32'(fifo_count), 0);
        chk("init_we", 32'(rf_we), 0);

        // 1: two slow entries held behind an rd=0 ALU stream, pending[9], then reset.
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd20; mem_wb_data = 32'hA0;
        pend_set_valid = 1'b1; pend_set_rd = 5'd9; rs1_addr = 5'd9;
        step();
        pend_set_valid = 1'b0;
        mem_wb_rd = 5'd21; mem_wb_data = 32'hA1;
        step();
        mem_wb_valid = 1'b0; alu_wb_valid = 1'b0;
        chk("t1_pre_count", 32'(fifo_count), 2);
        chk("t1_pre_hazard", 32'(hazard_stall), 1);
        chk("t1_rd0_no_we", 32'(rf_we), 0);
        rst = 1'b0;
        step(); step();
        chk("t1_count", 32'(fifo_count), 0);
        chk("t1_we", 32'(rf_we), 0);
        chk("t1_rd", 32'(rf_rd), 0);
        chk("t1_wdata", rf_wdata, 0);
        chk("t1_hazard", 32'(hazard_stall), 0);
        chk("t1_mem_rdy", 32'(mem_wb_ready), 1);
        rst = 1'b1;
        rs1_addr = 5'd0;

        // 2: single fast write with empty FIFO.
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        #1;
        chk("t2_alu_rdy", 32'(alu_wb_ready), 1);
        step();
        alu_wb_valid = 1'b0;
        chk("t2_we", 32'(rf_we), 1);
        chk("t2_rd", 32'(rf_rd), 5);
        chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("t2_we_off", 32'(rf_we), 0);
        chk("t2_rd_hold", 32'(rf_rd), 5);

        // 3: starvation limit forces the slow head out after 3 fast grants.
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h11;
        step();
        mem_wb_valid = 1'b0;
        chk("t3_count1", 32'(fifo_count), 1);
        for (int k = 0; k < 3; k++) begin
            chk("t3_alu_rdy", 32'(alu_wb_ready), 1);
            step();
            chk("t3_fast_rd", 32'(rf_rd), 3);
        end
        chk("t3_alu_blocked", 32'(alu_wb_ready), 0);
        step();
        alu_wb_valid = 1'b0;
        chk("t3_slow_we", 32'(rf_we), 1);
        chk("t3_slow_rd", 32'(rf_rd), 7);
        chk("t3_slow_wdata", rf_wdata, 32'h11);
        chk("t3_count0", 32'(fifo_count), 0);
        chk("t3_starve0", 32'(dut.starve_cnt), 0);

        // 4: fill to full under a continuous ALU stream; check ordering.
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
        exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b1;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
        idx = 0;
        cyc = 0;
        while (q_rd.size() < 6 && cyc < 200) begin
            mem_wb_valid = (idx < 6);
            mem_wb_rd    = 5'(10 + idx);
            mem_wb_data  = 32'(32'h100 + idx);
            #1;
            if (cyc < 6) chk("t4_mem_rdy", 32'(mem_wb_ready), 32'(exp_rdy[cyc]));
            if (cyc == 4) begin
                chk("t4_full_count", 32'(fifo_count), 4);
                chk("t4_alu_blocked", 32'(alu_wb_ready), 0);
            end
            if (mem_wb_valid && mem_wb_ready) idx++;
            step();
            if (rf_we && rf_rd >= 5'd10 && rf_rd <= 5'd15) begin
                q_rd.push_back(rf_rd);
                q_dat.push_back(rf_wdata);
            end
            cyc++;
        end
        mem_wb_valid = 1'b0;
        alu_wb_valid = 1'b0;
        chk("t4_slow_writes", 32'(q_rd.size()), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < q_rd.size()) begin
                chk("t4_order_rd", 32'(q_rd[k]), 32'(10 + k));
                chk("t4_order_dat", q_dat[k], 32'(32'h100 + k));
            end
        end
        step(); step();
        chk("t4_drained", 32'(fifo_count), 0);

        // 5: scoreboard set/clear, and set winning over a same-cycle clear.
        rs1_addr = 5'd9;
        chk("t5_idle_hazard", 32'(hazard_stall), 0);
        pend_set_valid = 1'b1; pend_set_rd = 5'd9;
        step();
        pend_set_valid = 1'b0;
        chk("t5_set_hazard", 32'(hazard_stall), 1);
        rs1_addr = 5'd0; rs2_addr = 5'd9;
        #1;
        chk("t5_rs2_hazard", 32'(hazard_stall), 1);
        rs1_addr = 5'd9; rs2_addr = 5'd0;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = 32'h99;
        step();
        mem_wb_valid = 1'b0;
        chk("t5_queued_hazard", 32'(hazard_stall), 1);
        step();
        chk("t5_wb_we", 32'(rf_we), 1);
        chk("t5_wb_rd", 32'(rf_rd), 9);
        chk("t5_wb_cycle_hazard", 32'(hazard_stall), 1);
        step();
        chk("t5_cleared", 32'(hazard_stall), 0);
        pend_set_valid = 1'b1;
        step();
        pend_set_valid = 1'b0;
        mem_wb_valid = 1'b1;
        step();
        mem_wb_valid = 1'b0;
        step();
        chk("t5b_wb_rd", 32'(rf_rd), 9);
        pend_set_valid = 1'b1;
        step();
        pend_set_valid = 1'b0;
        chk("t5b_set_wins", 32'(hazard_stall), 1);

        // 6: rd=0 writes are consumed but never enable the write port.
        rs1_addr = 5'd0;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'hFFFF;
        step();
        mem_wb_valid = 1'b0;
        chk("t6_count1", 32'(fifo_count), 1);
        step();
        chk("t6_count0", 32'(fifo_count), 0);
        chk("t6_slow_we", 32'(rf_we), 0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234;
        #1;
        chk("t6_alu_rdy", 32'(alu_wb_ready), 1);
        step();
        alu_wb_valid = 1'b0;
        chk("t6_fast_we", 32'(rf_we), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
